// File: rtl/peridot_hostbridge_pkg.sv
// Host-bridge framing definitions shared by the RX bytes_to_packets decoder
// and the TX packets_to_bytes encoder.
package peridot_hostbridge_pkg;

    localparam logic [7:0] SOP     = 8'h7A;
    localparam logic [7:0] EOP     = 8'h7B;
    localparam logic [7:0] CHAN    = 8'h7C;
    localparam logic [7:0] ESC     = 8'h7D;
    localparam logic [7:0] ESC_XOR = 8'h20;

    typedef enum logic [1:0] {
        S_DATA     = 2'd0,
        S_ESC      = 2'd1,
        S_CHAN     = 2'd2,
        S_CHAN_ESC = 2'd3
    } hb_state_e;

endpackage

// File: rtl/peridot_st_bytes_to_packets.sv
// Decodes the host-bridge framed byte stream into an Avalon-ST packet stream.
// Optional error tracking: define PERIDOT_ST_BYTES_TO_PACKETS_ERRCHECK_EN.
module peridot_st_bytes_to_packets
    import peridot_hostbridge_pkg::*;
#(
    parameter int CHANNEL_WIDTH = 8,
    parameter int RESET_CHANNEL = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    output logic                     in_ready,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    output logic [CHANNEL_WIDTH-1:0] out_channel
`ifdef PERIDOT_ST_BYTES_TO_PACKETS_ERRCHECK_EN
    ,
    output logic                     err_sticky,
    input  logic                     err_clear
`endif
);

    hb_state_e                state_q, state_d;
    logic                     sop_pend_q, sop_pend_d;
    logic                     eop_pend_q, eop_pend_d;
    logic [CHANNEL_WIDTH-1:0] chan_q, chan_d;
    logic                     accept;
    logic                     load;
    logic [7:0]               pay_byte;
    logic [7:0]               unesc;
    logic                     sop_mark;
    logic                     chan_abort;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign unesc    = in_data ^ ESC_XOR;

    always_comb begin
        state_d    = state_q;
        sop_pend_d = sop_pend_q;
        eop_pend_d = eop_pend_q;
        chan_d     = chan_q;
        load       = 1'b0;
        pay_byte   = in_data;
        sop_mark   = 1'b0;
        chan_abort = 1'b0;
        if (accept) begin
            case (state_q)
                S_ESC: begin
                    load     = 1'b1;
                    pay_byte = unesc;
                    state_d  = S_DATA;
                end
                S_CHAN_ESC: begin
                    chan_d  = unesc[CHANNEL_WIDTH-1:0];
                    state_d = S_DATA;
                end
                default: begin
                    // S_CHAN shares this path: a marker there abandons the channel update
                    state_d    = S_DATA;
                    chan_abort = (state_q == S_CHAN) &&
                                 (in_data == SOP || in_data == EOP || in_data == CHAN);
                    case (in_data)
                        SOP: begin
                            sop_pend_d = 1'b1;
                            sop_mark   = 1'b1;
                        end
                        EOP:  eop_pend_d = 1'b1;
                        CHAN: state_d = S_CHAN;
                        ESC:  state_d = (state_q == S_CHAN) ? S_CHAN_ESC : S_ESC;
                        default: begin
                            if (state_q == S_CHAN) chan_d = in_data[CHANNEL_WIDTH-1:0];
                            else                   load   = 1'b1;
                        end
                    endcase
                end
            endcase
        end
        if (load) begin
            sop_pend_d = 1'b0;
            eop_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= S_DATA;
            sop_pend_q        <= 1'b0;
            eop_pend_q        <= 1'b0;
            chan_q            <= CHANNEL_WIDTH'(RESET_CHANNEL);
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            out_channel       <= CHANNEL_WIDTH'(RESET_CHANNEL);
        end else begin
            state_q    <= state_d;
            sop_pend_q <= sop_pend_d;
            eop_pend_q <= eop_pend_d;
            chan_q     <= chan_d;
            if (load) begin
                out_valid         <= 1'b1;
                out_data          <= pay_byte;
                out_startofpacket <= sop_pend_q;
                out_endofpacket   <= eop_pend_q;
                out_channel       <= chan_q;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef PERIDOT_ST_BYTES_TO_PACKETS_ERRCHECK_EN
    logic pkt_open_q, pkt_open_d;
    logic err_q, err_d;

    always_comb begin
        pkt_open_d = pkt_open_q;
        if (load && sop_pend_q) pkt_open_d = 1'b1;
        if (load && eop_pend_q) pkt_open_d = 1'b0;
        err_d = err_q;
        if ((load && !pkt_open_q && !sop_pend_q) || (sop_mark && pkt_open_q) || chan_abort)
            err_d = 1'b1;
        if (err_clear) err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_open_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            pkt_open_q <= pkt_open_d;
            err_q      <= err_d;
        end
    end

    assign err_sticky = err_q;
`endif

endmodule

// File: tb/tb_peridot_st_bytes_to_packets.sv
// Randomized and directed bench for peridot_st_bytes_to_packets against a
// stream-parsing reference model.
module tb_peridot_st_bytes_to_packets;

    localparam int CW      = 8;
    localparam int RST_CH  = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_ready;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          out_ready;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_startofpacket;
    logic          out_endofpacket;
    logic [CW-1:0] out_channel;
    logic          err_clear;
`ifdef PERIDOT_ST_BYTES_TO_PACKETS_ERRCHECK_EN
    logic          err_sticky;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [17:0] obs_q[$];
    logic [17:0] exp_q[$];
    logic [7:0]  model_chan;
    logic [17:0] cur;

    assign cur = {out_data, out_startofpacket, out_endofpacket, out_channel};

    peridot_st_bytes_to_packets #(
        .CHANNEL_WIDTH(CW),
        .RESET_CHANNEL(RST_CH)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_ready         (in_ready),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .out_ready        (out_ready),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_startofpacket(out_startofpacket),
        .out_endofpacket  (out_endofpacket),
        .out_channel      (out_channel)
`ifdef PERIDOT_ST_BYTES_TO_PACKETS_ERRCHECK_EN
        ,
        .err_sticky       (err_sticky),
        .err_clear        (err_clear)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] mk(input logic [7:0] d, input bit s, input bit e,
                                       input logic [7:0] c);
        return {d, s, e, c};
    endfunction

    // Reference: parse the whole framed stream as a byte array.
    task automatic model_decode(input logic [7:0] s[$]);
        bit         sop = 0;
        bit         eop = 0;
        int         i   = 0;
        logic [7:0] x;
        while (i < s.size()) begin
            x = s[i];
            if (x == 8'h7A) begin
                sop = 1; i++;
            end else if (x == 8'h7B) begin
                eop = 1; i++;
            end else if (x == 8'h7D) begin
                if (i + 1 < s.size()) begin
                    exp_q.push_back(mk(s[i+1] ^ 8'h20, sop, eop, model_chan));
                    sop = 0; eop = 0;
                end
                i += 2;
            end else if (x == 8'h7C) begin
                i++;
                if (i < s.size()) begin
                    x = s[i];
                    if (x == 8'h7D) begin
                        if (i + 1 < s.size()) model_chan = s[i+1] ^ 8'h20;
                        i += 2;
                    end else if (x != 8'h7A && x != 8'h7B && x != 8'h7C) begin
                        model_chan = x;
                        i++;
                    end
                end
            end else begin
                exp_q.push_back(mk(x, sop, eop, model_chan));
                sop = 0; eop = 0;
                i++;
            end
        end
    endtask

    // mode 0: always ready, 1: random valid/ready, 2: 5-cycle output stall early on
    task automatic run(input logic [7:0] s[$], input int mode);
        int          idx = 0;
        int          cyc = 0;
        int          idle = 0;
        bit          stall_prev = 0;
        logic [17:0] held = '0;
        obs_q.delete();
        while (idle < 8 && cyc < 5000) begin
            @(negedge clk);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = !(cyc >= 3 && cyc < 8);
            endcase
            if (idx < s.size() && (mode != 1 || $urandom_range(0, 4) != 0)) begin
                in_valid = 1'b1;
                in_data  = s[idx];
            end else begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end
            #1;
            if (stall_prev) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_fields", 32'(cur), 32'(held));
            end
            if (out_valid && !out_ready) check("stall_in_ready", 32'(in_ready), 32'd0);
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) obs_q.push_back(cur);
            stall_prev = out_valid && !out_ready;
            held       = cur;
            if (idx >= s.size() && out_ready) idle++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("all_bytes_accepted", 32'(idx), 32'(s.size()));
    endtask

    task automatic compare(input string tag);
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check(tag, 32'(obs_q[i]), 32'(exp_q[i]));
        exp_q.delete();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_sop", 32'(out_startofpacket), 32'd0);
        check("rst_eop", 32'(out_endofpacket), 32'd0);
        check("rst_chan", 32'(out_channel), 32'(RST_CH));
        repeat (2) @(negedge clk);
        reset_n    = 1'b1;
        model_chan = 8'(RST_CH);
    endtask

    initial begin
        logic [7:0] s[$];
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        err_clear = 1'b0;
        model_chan = 8'(RST_CH);
        repeat (2) @(negedge clk);
        #1;
        check("init_valid", 32'(out_valid), 32'd0);
        check("init_chan", 32'(out_channel), 32'(RST_CH));
        check("init_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        s = '{8'h7A, 8'h7C, 8'h03, 8'h11, 8'h22, 8'h7B, 8'h33};
        run(s, 0);
        exp_q.push_back(mk(8'h11, 1, 0, 8'h03));
        exp_q.push_back(mk(8'h22, 0, 0, 8'h03));
        exp_q.push_back(mk(8'h33, 0, 1, 8'h03));
        compare("framing");

        s = '{8'h7A, 8'h7D, 8'h5A, 8'h7B, 8'h7D, 8'h5D};
        run(s, 0);
        exp_q.push_back(mk(8'h7A, 1, 0, 8'h03));
        exp_q.push_back(mk(8'h7D, 0, 1, 8'h03));
        compare("escape");

        s = '{8'h7C, 8'h7D, 8'h5C, 8'h7A, 8'h7B, 8'h44};
        run(s, 0);
        exp_q.push_back(mk(8'h44, 1, 1, 8'h7C));
        compare("chan_esc_single");

        s = '{8'h7A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h7B, 8'h05};
        run(s, 2);
        exp_q.push_back(mk(8'h01, 1, 0, 8'h7C));
        exp_q.push_back(mk(8'h02, 0, 0, 8'h7C));
        exp_q.push_back(mk(8'h03, 0, 0, 8'h7C));
        exp_q.push_back(mk(8'h04, 0, 0, 8'h7C));
        exp_q.push_back(mk(8'h05, 0, 1, 8'h7C));
        compare("backpressure");

        s = '{8'h7A, 8'h7C};
        run(s, 0);
        compare("pre_reset_chan");
        pulse_reset();
        s = '{8'h55};
        run(s, 0);
        exp_q.push_back(mk(8'h55, 0, 0, 8'(RST_CH)));
        compare("post_reset_chan");

        s = '{8'h7A, 8'h7D};
        run(s, 0);
        compare("pre_reset_esc");
        pulse_reset();
        s = '{8'h55};
        run(s, 0);
        exp_q.push_back(mk(8'h55, 0, 0, 8'(RST_CH)));
        compare("post_reset_esc");

        for (int pass = 0; pass < 2; pass++) begin
            pulse_reset();
            s.delete();
            for (int i = 0; i < 400; i++) begin
                int unsigned r;
                r = $urandom_range(0, 9);
                if (r < 4) s.push_back(8'h7A + 8'(r));
                else       s.push_back(8'($urandom));
            end
            model_decode(s);
            run(s, (pass == 0) ? 1 : 0);
            compare(pass == 0 ? "random_bp" : "random_free");
        end

`ifdef PERIDOT_ST_BYTES_TO_PACKETS_ERRCHECK_EN
        pulse_reset();
        #1;
        check("err_reset", 32'(err_sticky), 32'd0);
        s = '{8'h66};
        run(s, 0);
        check("err_orphan", 32'(err_sticky), 32'd1);
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        #1;
        check("err_cleared", 32'(err_sticky), 32'd0);
        s = '{8'h7A, 8'h01, 8'h7B, 8'h02};
        run(s, 0);
        check("err_good_pkt", 32'(err_sticky), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/peridot_st_bytes_to_packets.md
Name: peridot_st_bytes_to_packets

Overview:
- Sits directly downstream of the FT245 phy RX source and consumes its 8-bit Avalon-ST byte stream.
- Decodes the host-bridge framing code (SOP, EOP, channel and escape markers) into an Avalon-ST packet stream carrying startofpacket, endofpacket and channel.
- Feeds the hostbridge transaction/packet layer.
- Fully registered output; one byte of buffering; no bytes dropped under backpressure.

Parameters:
- CHANNEL_WIDTH, 8: width of out_channel (1..8). The decoded channel byte is truncated to its low CHANNEL_WIDTH bits.
- RESET_CHANNEL, 0: out_channel value after reset.

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_ready  out  1  ST sink ready
- in_valid  in  1  ST sink valid
- in_data  in  8  ST sink byte (framed stream)
- out_ready  in  1  ST source ready
- out_valid  out  1  ST source valid
- out_data  out  8  decoded payload byte
- out_startofpacket  out  1  first byte of packet
- out_endofpacket  out  1  last byte of packet
- out_channel  out  CHANNEL_WIDTH  channel of the current byte

Behaviour:
- Reset values: out_valid=0, out_data=0, out_startofpacket=0, out_endofpacket=0, out_channel=RESET_CHANNEL. The FSM goes to S_DATA and both pending flags clear. Reset mid-packet discards all state; no partial flush.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A byte is accepted when in_valid && in_ready.
  - out_valid drops on out_ready when no new payload byte is loaded that cycle.
  - Output fields hold stable while out_valid && !out_ready.
- Latency: an accepted payload byte appears on out_* the next cycle. Control bytes produce no output beat.
- Markers: SOP=0x7A, EOP=0x7B, CHAN=0x7C, ESC=0x7D.
- S_DATA:
  - 0x7A sets sop_pend.
  - 0x7B sets eop_pend.
  - 0x7C goes to S_CHAN.
  - 0x7D goes to S_ESC.
  - Any other byte is payload.
- S_ESC: the next byte, of any value, is payload (in_data ^ 0x20); return to S_DATA.
- S_CHAN:
  - 0x7D goes to S_CHAN_ESC.
  - 0x7A, 0x7B or 0x7C aborts the channel update and is processed exactly as in S_DATA.
  - Any other byte sets chan_reg and returns to S_DATA.
- S_CHAN_ESC: chan_reg = in_data ^ 0x20; return to S_DATA.
- Payload load:
  - out_data = decoded byte; out_startofpacket = sop_pend; out_endofpacket = eop_pend; out_channel = chan_reg.
  - Both pending flags clear on the load.
- EOP semantics: an EOP marker tags the next payload byte as last. If SOP and EOP are both pending, the result is a single-byte packet with sop=eop=1.
- Repeated markers: a second SOP or EOP while already pending has no additional effect.
- Channel persistence: chan_reg persists across packets and changes only on a CHAN sequence.
- Backpressure: no input is accepted while the output is stalled, so pending state can never be overwritten.

Optional Feature:
- Macro: PERIDOT_ST_BYTES_TO_PACKETS_ERRCHECK_EN.
- With the macro defined, the block adds:
  - output err_sticky (1)
  - input err_clear (1)
  - an internal pkt_open flag, set on a load with sop and cleared on a load with eop.
- err_sticky sets on any of:
  - payload while !pkt_open && !sop_pend;
  - SOP marker while pkt_open;
  - aborted CHAN sequence.
- err_clear has priority over a same-cycle set.
- err_sticky resets to 0.
- Decode behaviour is unchanged either way.
- Without the macro: no extra ports or logic.

Decomposition:
- Shared package peridot_hostbridge_pkg holds:
  - marker constants SOP/EOP/CHAN/ESC;
  - ESC_XOR = 0x20;
  - the FSM state encoding (S_DATA, S_ESC, S_CHAN, S_CHAN_ESC).
- The TX-side packets_to_bytes encoder reuses the same package.
- No sub-module; the decoder FSM and output register live in a single module.

Test Plan:
- Framing: feed 7A 7C 03 11 22 7B 33 with out_ready=1. Expect 3 beats: 11(sop,ch3), 22(ch3), 33(eop,ch3).
- Escape: feed 7A 7D 5A 7B 7D 5D. Expect 7A(sop), then 7D(eop).
- Escaped channel and single-byte packet: feed 7C 7D 5C 7A 7B 44. Expect one beat 44 with sop=1, eop=1, channel=0x7C (at CHANNEL_WIDTH=8).
- Backpressure: hold out_ready=0 for 5 cycles mid-packet. in_ready must be 0, out_* stable, and no byte lost or duplicated when released.
- Reset: assert reset_n=0 after 7C (in S_CHAN) and after 7D. After release, 55 appears as plain payload with sop=0, channel=RESET_CHANNEL, all outputs 0 during reset.
- ERRCHECK build:
  - payload 66 with no SOP sets err_sticky;
  - err_clear=1 clears it;
  - a correct packet 7A 01 7B 02 leaves it 0.
